// File: rtl/popcount_neuron_seq.sv
// Ternary neuron sequencer: time-shares one external 24-input popcount over NCHUNK chunks.
// Optional macro POPCNT_SKIP_ZERO_EN skips steps whose selected mask chunk is all-zero.
module popcount_neuron_seq #(
    parameter int NCHUNK = 4,
    parameter int ACC_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCHUNK*24-1:0]   in_x,
    input  logic [NCHUNK*24-1:0]   in_wpos,
    input  logic [NCHUNK*24-1:0]   in_wneg,
    input  logic [ACC_W-1:0]       in_thr,
    output logic [23:0]            pc_in,
    output logic                   pc_en,
    input  logic [4:0]             pc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_act
);
    localparam int NSTEP = 2 * NCHUNK;
    localparam int SW    = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [NCHUNK*24-1:0] x_r, wpos_r, wneg_r;
    logic [ACC_W-1:0]     thr_r, acc, acc_nx, pc_ext;
    logic [SW-1:0]        step, step_nx, step_first;
    logic                 last;
    logic [23:0]          x_k, m_k;

`ifdef POPCNT_SKIP_ZERO_EN
    // Lowest step index >= from whose selected mask chunk is nonzero; NSTEP if none.
    function automatic logic [SW-1:0] next_nz(input logic [NCHUNK*24-1:0] wp,
                                              input logic [NCHUNK*24-1:0] wn,
                                              input int unsigned from);
        logic [SW-1:0] r;
        logic          found;
        logic [23:0]   m;
        r     = SW'(NSTEP);
        found = 1'b0;
        for (int unsigned i = 0; i < NSTEP; i++) begin
            m = i[0] ? wn[24*(i/2) +: 24] : wp[24*(i/2) +: 24];
            if (!found && i >= from && m != '0) begin
                r     = SW'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        x_k = '0;
        m_k = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (step[SW-1:1] == (SW-1)'(k)) begin
                x_k = x_r[24*k +: 24];
                m_k = step[0] ? wneg_r[24*k +: 24] : wpos_r[24*k +: 24];
            end
        end
    end

    // A RUN cycle with step==NSTEP (all masks zero) executes nothing.
    always_comb begin
        in_ready = (state == IDLE);
`ifdef POPCNT_SKIP_ZERO_EN
        pc_en      = (state == RUN) && (step != SW'(NSTEP));
        step_nx    = next_nz(wpos_r, wneg_r, {{(32-SW){1'b0}}, step} + 32'd1);
        step_first = next_nz(in_wpos, in_wneg, 32'd0);
        last       = (step_nx == SW'(NSTEP));
`else
        pc_en      = (state == RUN);
        step_nx    = step + SW'(1);
        step_first = '0;
        last       = (step == SW'(NSTEP - 1));
`endif
        pc_in  = pc_en ? (x_k & m_k) : '0;
        pc_ext = pc_en ? {{(ACC_W-5){1'b0}}, pc_out} : '0;
        acc_nx = step[0] ? (acc - pc_ext) : (acc + pc_ext);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r       <= '0;
            wpos_r    <= '0;
            wneg_r    <= '0;
            thr_r     <= '0;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_act   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_r    <= in_x;
                    wpos_r <= in_wpos;
                    wneg_r <= in_wneg;
                    thr_r  <= in_thr;
                    acc    <= '0;
                    step   <= step_first;
                end
                RUN: begin
                    acc  <= acc_nx;
                    step <= step_nx;
                    if (last) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc_nx;
                        out_act   <= ($signed(acc_nx) >= $signed(thr_r));
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_neuron_seq.sv
// Directed self-checking bench for popcount_neuron_seq with an exact popcount model on pc_out.
module tb_popcount_neuron_seq;
    localparam int NCHUNK = 4;
    localparam int ACC_W  = 8;
    localparam int W      = NCHUNK * 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_x = '0, in_wpos = '0, in_wneg = '0;
    logic [ACC_W-1:0] in_thr = '0;
    logic [23:0]      pc_in;
    logic             pc_en;
    logic [4:0]       pc_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic             out_act;

    int checks = 0;
    int errors = 0;
    logic [23:0] pcs  [8];
    logic        pens [8];

    always #5 clk = ~clk;

    assign pc_out = 5'($countones(pc_in));

    popcount_neuron_seq #(.NCHUNK(NCHUNK), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_wpos(in_wpos), .in_wneg(in_wneg), .in_thr(in_thr),
        .pc_in(pc_in), .pc_en(pc_en), .pc_out(pc_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] wp, input logic [W-1:0] wn);
        int n;
        n = 0;
`ifdef POPCNT_SKIP_ZERO_EN
        for (int k = 0; k < NCHUNK; k++) begin
            if (wp[24*k +: 24] != '0) n++;
            if (wn[24*k +: 24] != '0) n++;
        end
        if (n == 0) n = 1;
`else
        n = 2 * NCHUNK;
`endif
        return n;
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] wp,
                        input logic [W-1:0] wn, input int thr, output int lat);
        @(negedge clk);
        check("in_ready_idle", int'(in_ready), 1);
        in_x     = x;
        in_wpos  = wp;
        in_wneg  = wn;
        in_thr   = ACC_W'(thr);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (lat < 8) begin
                pcs[lat]  = pc_in;
                pens[lat] = pc_en;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_clr", int'(out_valid), 0);
        check("in_ready_back", int'(in_ready), 1);
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] x, input logic [W-1:0] wp,
                            input logic [W-1:0] wn, input int thr,
                            input int exp_sum, input int exp_act);
        int lat;
        send(x, wp, wn, thr, lat);
        check({tag, "_lat"}, lat, exp_lat(wp, wn));
        check({tag, "_sum"}, int'($signed(out_sum)), exp_sum);
        check({tag, "_act"}, int'(out_act), exp_act);
        release_out();
    endtask

    localparam logic [W-1:0] ONES = '1;

    initial begin
        logic [ACC_W-1:0] held_sum;
        logic [23:0]      exp_pc [8];
        int               lat;

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_pc_en", int'(pc_en), 0);
        check("rst_pc_in", int'(pc_in), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_act", int'(out_act), 0);
        @(negedge clk);
        rst = 1'b0;

        run_case("allpos", ONES, ONES, '0, 50, 96, 1);
        run_case("allneg_eq", ONES, '0, ONES, -96, -96, 1);
        run_case("allneg_gt", ONES, '0, ONES, -95, -96, 0);

        send(ONES, {72'h0, 24'h00000F}, {24'h0, 24'hFFFFFF, 48'h0}, 0, lat);
        check("mix_sum", int'($signed(out_sum)), -20);
        check("mix_act", int'(out_act), 0);
`ifndef POPCNT_SKIP_ZERO_EN
        exp_pc = '{24'h00000F, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0};
        check("mix_lat", lat, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pc_in_s%0d", i), int'(pcs[i]), int'(exp_pc[i]));
            check($sformatf("pc_en_s%0d", i), int'(pens[i]), 1);
        end
`else
        check("mix_lat", lat, 2);
`endif
        release_out();

        // sum exactly equal to threshold
        run_case("thr_eq", {24'h000001, 24'h0, 24'hFFFFFF, 24'h0},
                 {48'h0, 24'h0000FF, 24'h0}, {24'h000003, 72'h0}, 7, 7, 1);
        run_case("one_chunk", ONES, {48'h0, 24'h00F0F0, 24'h0}, '0, 9, 8, 0);
        run_case("all_zero", ONES, '0, '0, 0, 0, 1);

        // backpressure in DONE with a competing in_valid
        send(ONES, ONES, '0, 50, lat);
        check("bp_lat", lat, exp_lat(ONES, '0));
        held_sum = out_sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_x = '0; in_wpos = ONES; in_wneg = ONES; in_thr = '0;
            in_valid = 1'b1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_sum", int'(out_sum), int'(held_sum));
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_sum_end", int'($signed(out_sum)), 96);
        release_out();
        @(negedge clk);
        check("bp_no_start", int'(pc_en), 0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        in_x = ONES; in_wpos = ONES; in_wneg = '0; in_thr = 8'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_pc_en", int'(pc_en), 1);
        rst = 1'b1;
        #1;
        check("arst_pc_en", int'(pc_en), 0);
        check("arst_pc_in", int'(pc_in), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_sum", int'(out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        run_case("after_rst", ONES, ONES, '0, 100, 96, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/popcount_neuron_seq.md
Name: popcount_neuron_seq

Overview:
- Sequencer that time-shares one external 24-input (approximate) popcount unit to evaluate a ternary neuron over NCHUNK*24 inputs.
- Per chunk it runs two passes: x & wpos, which is added to the accumulator, then x & wneg, which is subtracted.
- The signed sum is compared against a threshold to give a binary activation.
- Sits between the input sensor buffer and the next layer in the printed NN pipeline.

Parameters:
- NCHUNK, 4, number of 24-bit input chunks per neuron.
- ACC_W, 8, signed accumulator/threshold width. Must be >= clog2(NCHUNK*31+1)+1 so that worst-case approximate pc_out (max 31 per pass) cannot overflow.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- in_x  in  NCHUNK*24  input activations; chunk k = bits [24k+23:24k].
- in_wpos  in  NCHUNK*24  positive-weight mask.
- in_wneg  in  NCHUNK*24  negative-weight mask.
- in_thr  in  ACC_W  signed threshold.
- pc_in  out  24  operand to external popcount unit.
- pc_en  out  1  popcount operand valid (power/debug gating).
- pc_out  in  5  combinational result from popcount unit, same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  signed sum of positive passes minus negative passes.
- out_act  out  1  1 when out_sum >= in_thr (signed compare).

Behaviour:
- Reset values: state=IDLE, step=0, acc=0, out_valid=0, out_sum=0, out_act=0, pc_en=0, pc_in=0, in_ready=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch x, wpos, wneg, thr; acc<=0; step<=0; go RUN.
- RUN:
  - in_ready=0; pc_en=1.
  - Step s in 0..2*NCHUNK-1; chunk k=s>>1.
  - pc_in = x_k & (s even ? wpos_k : wneg_k).
  - Each cycle: acc <= acc + zext(pc_out) for even s, acc - zext(pc_out) for odd s.
  - At s=2*NCHUNK-1: go DONE and register out_sum=final acc, out_act=(final acc >= thr).
- DONE:
  - out_valid=1; out_sum and out_act held stable.
  - On out_ready: out_valid<=0, go IDLE.
  - in_valid is ignored while in RUN or DONE.
- pc_in=0 and pc_en=0 whenever not in RUN.
- Latency: out_valid rises 2*NCHUNK cycles after the accept edge (8 for default).
- Throughput: one neuron per 2*NCHUNK+2 cycles when out_ready is held high.
- Arithmetic: two's complement, ACC_W bits. No saturation needed given the parameter constraint.
- out_act uses the latched thr, not the live in_thr.
- Async reset at any point, including mid-RUN or in DONE with out_valid=1: immediate return to reset values. The in-flight operation is discarded, with no output produced.
- out_ready asserted outside DONE has no effect.

Optional Feature:
- POPCNT_SKIP_ZERO_EN: when defined, RUN skips any step whose selected mask chunk is all-zero.
  - Next step = lowest remaining index with a nonzero mask chunk, found combinationally.
  - The skipped contribution is 0.
  - Latency = number of nonzero mask chunks, minimum 1. If all masks are zero, DONE is reached 1 cycle after accept with out_sum=0.
  - pc_en is low on no executed cycle.
- Without the macro: fixed latency 2*NCHUNK regardless of mask content.

Test Plan:
- Bench drives pc_out from an exact popcount model.
- x=all-ones, wpos=all-ones, wneg=0, thr=50 -> out_sum=96, out_act=1, out_valid 8 cycles after accept.
- x=all-ones, wpos=0, wneg=all-ones, thr=-96 -> out_sum=-96, out_act=1; with thr=-95 -> out_act=0.
- Chunk0 wpos=0x00000F, chunk2 wneg=0xFFFFFF, x=all-ones, thr=0 -> out_sum=-20, out_act=0. pc_in sequence matches the masked chunks, one step per cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> in_ready=1 next cycle.
- Assert rst at step 3 of RUN -> all outputs immediately at reset values. A fresh operand set afterwards gives the correct sum.
- With POPCNT_SKIP_ZERO_EN and only chunk1 wpos nonzero -> out_valid 1 cycle after accept. With all masks zero -> out_sum=0 after 1 cycle.
